// File: rtl/dma_pkg.sv
// -----------------------------------------------------------------------------
// dma_pkg
// Shared definitions for the DMA channel arbiter slice.
//   arb_state_t        : one-hot arbiter FSM state
//   DMA_NUM_CH_DEFAULT : default channel count
//   DMA_MAX_CH         : widest channel vector any instance may use
//   DMA_IDX_W          : index width able to address DMA_MAX_CH channels
//   onehot(idx)        : DMA_MAX_CH-wide one-hot decode of a channel index
// -----------------------------------------------------------------------------
package dma_pkg;

    localparam int unsigned DMA_NUM_CH_DEFAULT = 4;
    localparam int unsigned DMA_MAX_CH         = 16;
    localparam int unsigned DMA_IDX_W          = 4;

    typedef enum logic [2:0] {
        ARB_IDLE  = 3'b001,
        ARB_REQ   = 3'b010,
        ARB_GRANT = 3'b100
    } arb_state_t;

    // Callers size-cast the result down to their own channel count.
    function automatic logic [DMA_MAX_CH-1:0] onehot(input logic [DMA_IDX_W-1:0] idx);
        logic [DMA_MAX_CH-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/dma_channel_arbiter_if.sv
// -----------------------------------------------------------------------------
// dma_channel_arbiter_if
// Request / acknowledge / configuration bundle of the DMA channel arbiter.
//   master : arbiter side  (drives HRQ, DACK, grant status, mask/soft state)
//   slave  : system side   (drives DREQ, software requests, mask pulses,
//                           mode bits, HLDA and timing-control completion)
// Parameter NUM_CH sets every per-channel vector width; CH_W is derived.
// -----------------------------------------------------------------------------
interface dma_channel_arbiter_if
    import dma_pkg::*;
#(
    parameter int unsigned NUM_CH = DMA_NUM_CH_DEFAULT
);
    localparam int unsigned CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0] DREQ;
    logic [NUM_CH-1:0] softwareReq;
    logic [NUM_CH-1:0] maskSet;
    logic [NUM_CH-1:0] maskClr;
    logic [NUM_CH-1:0] autoinitEn;
    logic              priorityType;
    logic              dreqActiveLow;
    logic              dackActiveHigh;
    logic              HLDA;
    logic              serviceDone;
    logic              terminalCount;

    logic              HRQ;
    logic [NUM_CH-1:0] DACK;
    logic              grantValid;
    logic [CH_W-1:0]   grantIdx;
    logic [NUM_CH-1:0] maskReg;
    logic [NUM_CH-1:0] softReqPending;

    modport master (
        input  DREQ, softwareReq, maskSet, maskClr, autoinitEn,
        input  priorityType, dreqActiveLow, dackActiveHigh,
        input  HLDA, serviceDone, terminalCount,
        output HRQ, DACK, grantValid, grantIdx, maskReg, softReqPending
    );

    modport slave (
        output DREQ, softwareReq, maskSet, maskClr, autoinitEn,
        output priorityType, dreqActiveLow, dackActiveHigh,
        output HLDA, serviceDone, terminalCount,
        input  HRQ, DACK, grantValid, grantIdx, maskReg, softReqPending
    );

endinterface

// File: rtl/dma_priority_resolver.sv
// -----------------------------------------------------------------------------
// dma_priority_resolver
// Combinational winner selection over the effective request vector.
//   pend_i    : effective per-channel requests
//   rot_ptr_i : channel currently holding highest priority in rotating mode
//   rotate_i  : 0 = fixed (channel 0 highest), 1 = rotating
//   winner_o  : index of the highest-priority requesting channel
//   any_o     : at least one channel is requesting
// -----------------------------------------------------------------------------
module dma_priority_resolver
    import dma_pkg::*;
#(
    parameter  int unsigned NUM_CH = DMA_NUM_CH_DEFAULT,
    localparam int unsigned CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] pend_i,
    input  logic [CH_W-1:0]   rot_ptr_i,
    input  logic              rotate_i,
    output logic [CH_W-1:0]   winner_o,
    output logic              any_o
);

    logic [CH_W-1:0]   base;
    logic [NUM_CH-1:0] rotated;
    logic [CH_W-1:0]   first;
    logic              found;
    int unsigned       sum;

    always_comb begin
        base = rotate_i ? rot_ptr_i : '0;

        // Doubling the vector makes the right shift a rotation: bit k of the
        // result is pend_i[(k + base) mod NUM_CH].
        rotated = NUM_CH'({pend_i, pend_i} >> base);

        first = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!found && rotated[i]) begin
                found = 1'b1;
                first = CH_W'(i);
            end
        end

        // Un-rotate back to an absolute channel index.
        sum = 32'(first) + 32'(base);
        if (sum >= NUM_CH) begin
            sum = sum - NUM_CH;
        end
        winner_o = CH_W'(sum);
        any_o    = found;
    end

endmodule

// File: rtl/dma_channel_arbiter.sv
// -----------------------------------------------------------------------------
// dma_channel_arbiter
// N-channel DMA request/priority/acknowledge unit.
//   CLK   : system clock, all state on the rising edge
//   RESET : synchronous active-high reset
//   bus   : dma_channel_arbiter_if.master
//           in : DREQ, softwareReq, maskSet, maskClr, autoinitEn,
//                priorityType, dreqActiveLow, dackActiveHigh,
//                HLDA, serviceDone, terminalCount
//           out: HRQ, DACK, grantValid, grantIdx, maskReg, softReqPending
// Merges hardware and software requests, applies the mask register, picks a
// winner (fixed or rotating priority) when the CPU grants the bus, and holds
// one-hot DACK on that channel until service completes or HLDA is lost.
// -----------------------------------------------------------------------------
module dma_channel_arbiter
    import dma_pkg::*;
#(
    parameter  int unsigned NUM_CH = DMA_NUM_CH_DEFAULT,
    localparam int unsigned CH_W   = $clog2(NUM_CH)
) (
    input  logic                 CLK,
    input  logic                 RESET,
    dma_channel_arbiter_if.master bus
);

    arb_state_t        state_q;
    logic              hrq_q;
    logic              grant_valid_q;
    logic [CH_W-1:0]   grant_idx_q;
    logic [CH_W-1:0]   rot_ptr_q, rot_ptr_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [NUM_CH-1:0] soft_q, soft_d;

    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] grant_oh;
    logic [NUM_CH-1:0] dack_hi;
    logic [CH_W-1:0]   winner;
    logic              any_req;
    logic              done_ok;
    logic              tc_hit;

    assign pend = ((bus.DREQ ^ {NUM_CH{bus.dreqActiveLow}}) & ~mask_q) | soft_q;

    dma_priority_resolver #(
        .NUM_CH (NUM_CH)
    ) u_resolver (
        .pend_i    (pend),
        .rot_ptr_i (rot_ptr_q),
        .rotate_i  (bus.priorityType),
        .winner_o  (winner),
        .any_o     (any_req)
    );

    assign grant_oh = NUM_CH'(onehot(DMA_IDX_W'(grant_idx_q)));

    // Completion only counts while a channel actually holds the grant.
    assign done_ok = (state_q == ARB_GRANT) && bus.serviceDone;
    assign tc_hit  = done_ok && bus.terminalCount;

    always_comb begin
        mask_d = (mask_q & ~bus.maskClr) | bus.maskSet;
        if (tc_hit && ((bus.autoinitEn & grant_oh) == '0)) begin
            mask_d = mask_d | grant_oh;
        end

        soft_d = soft_q;
        if (tc_hit) begin
            soft_d = soft_d & ~grant_oh;
        end
        soft_d = soft_d | bus.softwareReq;

        rot_ptr_d = rot_ptr_q;
        if (done_ok) begin
            rot_ptr_d = (grant_idx_q == CH_W'(NUM_CH - 1)) ? '0 : grant_idx_q + CH_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= ARB_IDLE;
            hrq_q         <= 1'b0;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= '0;
            rot_ptr_q     <= '0;
            mask_q        <= '1;
            soft_q        <= '0;
        end else begin
            mask_q    <= mask_d;
            soft_q    <= soft_d;
            rot_ptr_q <= rot_ptr_d;
            unique case (state_q)
                ARB_IDLE: begin
                    if (any_req) begin
                        state_q <= ARB_REQ;
                        hrq_q   <= 1'b1;
                    end
                end
                ARB_REQ: begin
                    if (!any_req) begin
                        state_q <= ARB_IDLE;
                        hrq_q   <= 1'b0;
                    end else if (bus.HLDA) begin
                        state_q       <= ARB_GRANT;
                        grant_valid_q <= 1'b1;
                        grant_idx_q   <= winner;
                    end
                end
                ARB_GRANT: begin
                    // serviceDone wins over a simultaneous HLDA drop, so
                    // that case still rotates via done_ok above.
                    if (bus.serviceDone || !bus.HLDA) begin
                        state_q       <= ARB_IDLE;
                        hrq_q         <= 1'b0;
                        grant_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= ARB_IDLE;
                    hrq_q         <= 1'b0;
                    grant_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign dack_hi = grant_valid_q ? grant_oh : '0;

    assign bus.HRQ            = hrq_q;
    assign bus.DACK           = bus.dackActiveHigh ? dack_hi : ~dack_hi;
    assign bus.grantValid     = grant_valid_q;
    assign bus.grantIdx       = grant_idx_q;
    assign bus.maskReg        = mask_q;
    assign bus.softReqPending = soft_q;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
module tb_dma_channel_arbiter;

    localparam int NCH = 4;

    logic CLK = 1'b0;
    logic RESET;

    always #5 CLK = ~CLK;

    dma_channel_arbiter_if #(.NUM_CH(NCH)) bus ();

    dma_channel_arbiter #(.NUM_CH(NCH)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         idx;
        logic [3:0] dack;
    } exp_t;

    exp_t exp_q[$];

    // Reference state: mask register, latched software requests and the
    // channel that currently has top priority in rotating mode.
    logic [3:0] m_mask;
    logic [3:0] m_soft;
    int         m_ptr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Walk the channels from highest to lowest priority; first requester wins.
    function automatic int ref_winner(input logic [3:0] pend, input bit rot, input int ptr);
        for (int k = 0; k < NCH; k++) begin
            int ch;
            ch = rot ? (ptr + k) % NCH : k;
            if (pend[ch]) return ch;
        end
        return -1;
    endfunction

    function automatic logic [3:0] dack_of(input int w, input bit high);
        logic [3:0] oh;
        oh = 4'b0001 << w;
        return high ? oh : ~oh;
    endfunction

    // Monitor: every new grant must match the oldest expected grant.
    initial begin : monitor
        logic gv_prev;
        exp_t e;
        gv_prev = 1'b0;
        forever begin
            @(negedge CLK);
            if (bus.grantValid === 1'b1 && !gv_prev) begin
                chk("grant_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("grant_idx", 32'(bus.grantIdx), e.idx);
                    chk("dack", 32'(bus.DACK), 32'(e.dack));
                    chk("hrq_in_grant", 32'(bus.HRQ), 1);
                end
            end
            gv_prev = (bus.grantValid === 1'b1);
        end
    end

    task automatic model_reset();
        m_mask = 4'hF;
        m_soft = 4'h0;
        m_ptr  = 0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        bus.DREQ = bus.dreqActiveLow ? 4'hF : 4'h0;
        bus.HLDA = 1'b0;
        bus.serviceDone = 1'b0;
        bus.terminalCount = 1'b0;
        tick();
        RESET = 1'b0;
        model_reset();
    endtask

    // kind: 0 done, 1 done+TC, 2 abort (HLDA drop), 3 done+TC with HLDA drop,
    //       4 RESET during grant
    task automatic run_txn(input logic [3:0] mset, input logic [3:0] mclr,
                           input logic [3:0] sw, input logic [3:0] ainit,
                           input logic [3:0] act, input bit prio, input bit alow,
                           input bit dhigh, input int hdly, input int hold,
                           input int kind);
        logic [3:0] pend;
        logic [3:0] inact;
        int         w;
        bit         tc;
        inact = alow ? 4'hF : 4'h0;

        bus.priorityType   = prio;
        bus.dreqActiveLow  = alow;
        bus.dackActiveHigh = dhigh;
        bus.autoinitEn     = ainit;
        bus.DREQ           = inact;
        bus.maskSet        = mset;
        bus.maskClr        = mclr;
        bus.softwareReq    = sw;
        bus.HLDA           = 1'b0;
        bus.serviceDone    = 1'b0;
        bus.terminalCount  = 1'b0;
        m_mask = (m_mask & ~mclr) | mset;
        m_soft = m_soft | sw;
        tick();

        bus.maskSet     = '0;
        bus.maskClr     = '0;
        bus.softwareReq = '0;
        bus.DREQ        = act ^ inact;
        tick();

        pend = (act & ~m_mask) | m_soft;
        @(negedge CLK);
        chk("hrq_on_request", 32'(bus.HRQ), 32'(pend != 0));
        chk("mask_reg", 32'(bus.maskReg), 32'(m_mask));
        chk("soft_pending", 32'(bus.softReqPending), 32'(m_soft));
        if (pend == 4'h0) begin
            bus.DREQ = inact;
            tick();
            return;
        end

        w = ref_winner(pend, prio, m_ptr);
        exp_q.push_back('{idx: w, dack: dack_of(w, dhigh)});

        tick();
        repeat (hdly) tick();
        bus.HLDA = 1'b1;
        tick();
        @(negedge CLK);
        chk("grant_latency", 32'(bus.grantValid), 1);
        if (bus.grantValid !== 1'b1) exp_q.delete();

        tick();
        repeat (hold) tick();
        case (kind)
            0: bus.serviceDone = 1'b1;
            1: begin bus.serviceDone = 1'b1; bus.terminalCount = 1'b1; end
            2: bus.HLDA = 1'b0;
            3: begin bus.serviceDone = 1'b1; bus.terminalCount = 1'b1; bus.HLDA = 1'b0; end
            default: RESET = 1'b1;
        endcase
        tick();
        bus.serviceDone   = 1'b0;
        bus.terminalCount = 1'b0;
        bus.HLDA          = 1'b0;
        RESET             = 1'b0;
        bus.DREQ          = inact;

        if (kind == 4) begin
            model_reset();
        end else if (kind != 2) begin
            tc = (kind == 1 || kind == 3);
            if (tc) begin
                m_soft[w] = 1'b0;
                if (!ainit[w]) m_mask[w] = 1'b1;
            end
            m_ptr = (w + 1) % NCH;
        end

        @(negedge CLK);
        chk("hrq_after_end", 32'(bus.HRQ), 0);
        chk("grant_after_end", 32'(bus.grantValid), 0);
        chk("dack_inactive", 32'(bus.DACK), dhigh ? 32'h0 : 32'hF);
        chk("mask_after_end", 32'(bus.maskReg), 32'(m_mask));
        chk("soft_after_end", 32'(bus.softReqPending), 32'(m_soft));
        if (kind == 4) chk("grant_idx_reset", 32'(bus.grantIdx), 0);
        tick();
    endtask

    initial begin : watchdog
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [3:0] r_mset, r_mclr, r_sw, r_ainit, r_act;
        int         r_kind;

        RESET              = 1'b1;
        bus.DREQ           = '0;
        bus.softwareReq    = '0;
        bus.maskSet        = '0;
        bus.maskClr        = '0;
        bus.autoinitEn     = '0;
        bus.priorityType   = 1'b0;
        bus.dreqActiveLow  = 1'b0;
        bus.dackActiveHigh = 1'b1;
        bus.HLDA           = 1'b0;
        bus.serviceDone    = 1'b0;
        bus.terminalCount  = 1'b0;
        model_reset();

        tick();
        @(negedge CLK);
        chk("rst_hrq", 32'(bus.HRQ), 0);
        chk("rst_grant_valid", 32'(bus.grantValid), 0);
        chk("rst_grant_idx", 32'(bus.grantIdx), 0);
        chk("rst_mask", 32'(bus.maskReg), 32'hF);
        chk("rst_soft", 32'(bus.softReqPending), 0);
        chk("rst_dack", 32'(bus.DACK), 0);
        RESET = 1'b0;
        tick();

        // Fixed priority, DREQ=1110 -> ch1
        run_txn(4'h0, 4'hF, 4'h0, 4'h0, 4'b1110, 1'b0, 1'b0, 1'b1, 1, 1, 0);

        // Rotating with all requesting: ch0, ch1, ch2
        do_reset();
        run_txn(4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 1'b1, 1'b0, 1'b1, 0, 0, 0);
        run_txn(4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 1'b1, 1'b0, 1'b1, 0, 0, 0);
        run_txn(4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 1'b1, 1'b0, 1'b1, 0, 0, 0);
        // Fixed: ch0 every time
        repeat (3) run_txn(4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b1, 0, 1, 0);

        // Masking and auto-mask on terminal count
        do_reset();
        run_txn(4'h0, 4'h0, 4'h0, 4'h0, 4'b0001, 1'b0, 1'b0, 1'b1, 0, 0, 0);
        run_txn(4'h0, 4'b0001, 4'h0, 4'h0, 4'b0001, 1'b0, 1'b0, 1'b1, 0, 0, 1);
        run_txn(4'h0, 4'b0001, 4'h0, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b1, 0, 0, 1);

        // Software request with every channel masked
        do_reset();
        run_txn(4'h0, 4'h0, 4'b0100, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 0, 0, 0);
        run_txn(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 0, 0, 1);

        // Inverted polarities: raw DREQ=1011 -> ch2, DACK=1011
        do_reset();
        run_txn(4'h0, 4'hF, 4'h0, 4'h0, 4'b0100, 1'b0, 1'b1, 1'b0, 1, 0, 0);

        // Abort keeps the rotation pointer, then reset during grant
        do_reset();
        run_txn(4'h0, 4'hF, 4'h0, 4'h0, 4'b0110, 1'b1, 1'b0, 1'b1, 0, 1, 2);
        run_txn(4'h0, 4'h0, 4'h0, 4'h0, 4'b0110, 1'b1, 1'b0, 1'b1, 0, 0, 0);
        run_txn(4'h0, 4'h0, 4'h0, 4'h0, 4'b1000, 1'b0, 1'b0, 1'b1, 0, 1, 4);

        // serviceDone outside GRANT is ignored
        do_reset();
        bus.dreqActiveLow  = 1'b0;
        bus.dackActiveHigh = 1'b1;
        bus.autoinitEn     = '0;
        bus.DREQ           = '0;
        bus.maskClr        = 4'b0001;
        bus.softwareReq    = 4'b0001;
        bus.serviceDone    = 1'b1;
        bus.terminalCount  = 1'b1;
        m_mask = 4'b1110;
        m_soft = 4'b0001;
        tick();
        bus.maskClr     = '0;
        bus.softwareReq = '0;
        tick();
        bus.serviceDone   = 1'b0;
        bus.terminalCount = 1'b0;
        @(negedge CLK);
        chk("idle_done_mask", 32'(bus.maskReg), 32'(m_mask));
        chk("idle_done_soft", 32'(bus.softReqPending), 32'(m_soft));
        chk("idle_done_hrq", 32'(bus.HRQ), 1);
        tick();
        do_reset();

        // Randomised transactions
        repeat (150) begin
            r_mset  = 4'($urandom) & 4'($urandom) & 4'($urandom);
            r_mclr  = 4'($urandom);
            r_sw    = ($urandom_range(0, 3) == 0) ? (4'($urandom) & 4'($urandom)) : 4'h0;
            r_ainit = 4'($urandom);
            r_act   = 4'($urandom);
            r_kind  = $urandom_range(0, 19);
            r_kind  = (r_kind < 8) ? 0 : (r_kind < 13) ? 1 : (r_kind < 16) ? 2 :
                      (r_kind < 19) ? 3 : 4;
            run_txn(r_mset, r_mclr, r_sw, r_ainit, r_act,
                    1'($urandom), 1'($urandom), 1'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3), r_kind);
        end

        repeat (3) tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dma_channel_arbiter.md
# dma_channel_arbiter

Parametrised N-channel request/priority/acknowledge unit for the DMA controller. It merges hardware `DREQ` and software requests, applies per-channel masks, and resolves priority as fixed or rotating. It runs the `HRQ`/`HLDA` bus handshake with the CPU and drives one-hot `DACK` to the winning channel until the timing-control block reports end of service. It replaces the hard-wired 4-channel priority logic and adds configurable channel count, request/acknowledge polarity, auto-masking on terminal count, and abort on `HLDA` loss.

## Interface
- `NUM_CH`, 4, number of DMA channels (2..16)
- `CH_W`, `$clog2(NUM_CH)`, width of a channel index (derived; not overridden)

- `CLK`  in  1  system clock; all state on rising edge
- `RESET`  in  1  synchronous, active-high reset
- `DREQ`  in  NUM_CH  hardware channel requests; polarity per `dreqActiveLow`
- `softwareReq`  in  NUM_CH  software request bits; not maskable
- `maskSet`  in  NUM_CH  one-cycle pulses that set mask bits
- `maskClr`  in  NUM_CH  one-cycle pulses that clear mask bits
- `autoinitEn`  in  NUM_CH  per-channel autoinitialise mode
- `priorityType`  in  1  0 = fixed (channel 0 highest), 1 = rotating
- `dreqActiveLow`  in  1  1 = `DREQ` is active low
- `dackActiveHigh`  in  1  1 = `DACK` is active high
- `HLDA`  in  1  CPU hold acknowledge
- `serviceDone`  in  1  one-cycle pulse from timing control: current transfer finished
- `terminalCount`  in  1  qualifies `serviceDone`: the granted channel reached TC
- `HRQ`  out  1  hold request to CPU
- `DACK`  out  NUM_CH  channel acknowledge, one-hot when active
- `grantValid`  out  1  a channel is currently granted
- `grantIdx`  out  CH_W  index of the granted channel
- `maskReg`  out  NUM_CH  current mask register
- `softReqPending`  out  NUM_CH  latched software requests

## Operation
- Effective request: `pend = ((DREQ ^ {NUM_CH{dreqActiveLow}}) & ~maskReg) | softReqPending`.
- `softReqPending[i]` sets on `softwareReq[i]`. It clears when channel i receives `serviceDone` with `terminalCount`.
- Mask updates: `maskSet` takes priority over `maskClr` on the same bit. On `serviceDone & terminalCount & !autoinitEn[g]`, bit `maskReg[g]` is set.
- FSM states:
  - `IDLE`: go to `REQ` when `pend != 0`.
  - `REQ`: go to `GRANT` when `HLDA == 1` and `pend != 0`. Go to `IDLE` when `pend == 0`.
  - `GRANT`: go to `IDLE` on `serviceDone`, or on `HLDA == 0` (abort).
- Winner selection happens on the edge leaving `REQ`. The winner is the highest-priority set bit of `pend` at that edge, and `grantIdx` is latched then. Requests arriving later do not pre-empt the grant.
- Priority order:
  - Fixed: channel 0 highest, channel NUM_CH-1 lowest.
  - Rotating: after `serviceDone` on channel g, channel g becomes lowest and channel (g+1) mod NUM_CH becomes highest.
  - An abort does not rotate.
- `HRQ` = 1 in `REQ` and `GRANT`.
- `DACK`:
  - `dackActiveHigh = 1`: `DACK = onehot(grantIdx)` in `GRANT`, all zeros otherwise.
  - `dackActiveHigh = 0`: `DACK = ~onehot(grantIdx)` in `GRANT`, all ones otherwise.
- `priorityType` or polarity changes while in `GRANT` take effect at the next arbitration.

## Timing
- Reset values: state `IDLE`, `HRQ` 0, `grantValid` 0, `grantIdx` 0, `maskReg` all ones (all channels masked), `softReqPending` 0, rotation pointer 0 (channel 0 highest). `DACK` sits at its inactive level.
- All outputs are registered, except that the `DACK` polarity inversion is applied combinationally from `dackActiveHigh`.
- Request seen at edge n raises `HRQ` in cycle n+1.
- `HLDA` seen high at edge m (state `REQ`) gives `DACK`/`grantValid` active in cycle m+1.
- `serviceDone` at edge k returns `DACK` inactive and `HRQ` 0 in cycle k+1. A re-request can raise `HRQ` no earlier than cycle k+2.
- `serviceDone` outside `GRANT` is ignored.
- `serviceDone` and `HLDA` falling on the same edge count as a normal completion (rotation applies).
- `RESET` in any state returns to reset values at the next edge, overriding all other inputs.

## Structure
- Shared package `dma_pkg`:
  - `arb_state_t` enum `{ARB_IDLE, ARB_REQ, ARB_GRANT}`, one-hot encoded
  - `DMA_NUM_CH_DEFAULT = 4`
  - function `onehot(idx)`
- Sub-module `dma_priority_resolver`: purely combinational.
  - Inputs: `pend`, rotation pointer, `priorityType`.
  - Outputs: winner index and `any`.
  - Implementation: rotate, find-first, un-rotate.
- The FSM, mask and software-request registers stay in `dma_channel_arbiter`.

## Test plan
- Fixed priority, NUM_CH=4, all unmasked, active-high, `DREQ=4'b1110`, `HLDA` raised 2 cycles after `HRQ` → `DACK=4'b0010` one cycle after `HLDA` is sampled. A `serviceDone` pulse → `DACK=0`, `HRQ=0` next cycle.
- Rotating, `DREQ=4'b1111` held, serve three times → grants in order ch0, ch1, ch2. With `priorityType=0` → ch0 every time.
- Mask: reset, then `DREQ=4'b0001` → `HRQ` stays 0. `maskClr=4'b0001` → `HRQ` rises next cycle. `serviceDone` with `terminalCount`, `autoinitEn=0` → `maskReg[0]` is 1 again. Same with `autoinitEn[0]=1` → `maskReg[0]` stays 0.
- Software request `softwareReq=4'b0100` with all channels masked → grant ch2. Pending bit clears only on TC.
- Polarity: `dreqActiveLow=1`, `dackActiveHigh=0`, `DREQ=4'b1011` → grant ch2, `DACK=4'b1011`.
- Abort and reset: `HLDA` drops in `GRANT` → state `IDLE`, no rotation. `RESET` during `GRANT` → all outputs at reset values next cycle.
